// File: rtl/sram_ctrl.sv
// Access sequencer for the SRAM macro: one request at a time, walking through
// bitline precharge, word-line pulse, optional sense, then a one-cycle response.
module sram_ctrl #(
  parameter int COLS    = 8,
  parameter int ROWS    = 16,
  parameter int ADDR_W  = $clog2(ROWS),
  parameter int PRE_CYC = 1,
  parameter int WL_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [COLS-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [COLS-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              pre_en,
  output logic [ROWS-1:0]   wl,
  output logic              wr_en,
  output logic [COLS-1:0]   data_in,
  output logic              sae,
  input  logic [COLS-1:0]   sa_out
);

  localparam int CNT_MAX = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, PRE, ACCESS, SENSE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              we_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              ready_reg;
  logic              accept;
  logic              req_oob;
  logic [ROWS-1:0]   wl_dec;

  assign req_ready = ready_reg;
  assign accept    = req_valid && ready_reg;
  assign req_oob   = (32'(req_addr) >= ROWS);

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_wl_dec
      assign wl_dec[gi] = (32'(addr_reg) == gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = PRE;
          cnt_next   = '0;
        end
      end
      PRE: begin
        if (cnt_reg == CNT_W'(PRE_CYC - 1)) begin
          state_next = ACCESS;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ACCESS: begin
        if (cnt_reg == CNT_W'(WL_CYC - 1)) begin
          state_next = we_reg ? DONE : SENSE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      SENSE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are loaded from the state being entered, so each one is a clean
  // register that is a pure function of the current state and latched request.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      addr_reg  <= '0;
      ready_reg <= 1'b1;
      data_in   <= '0;
      pre_en    <= 1'b0;
      wl        <= '0;
      wr_en     <= 1'b0;
      sae       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        we_reg   <= req_we;
        addr_reg <= req_addr;
        err_reg  <= req_oob;
        if (req_we) begin
          data_in <= req_wdata;
        end
      end
      ready_reg <= (state_next == IDLE);
      pre_en    <= (state_next == PRE);
      wl        <= ((state_next == ACCESS) && !err_reg) ? wl_dec : '0;
      wr_en     <= (state_next == ACCESS) && we_reg && !err_reg;
      sae       <= (state_next == SENSE);
      rsp_valid <= (state_next == DONE);
      rsp_err   <= (state_next == DONE) && err_reg;
      // Out-of-range reads still strobe the sense amps but must not disturb rsp_rdata.
      if ((state_reg == SENSE) && !err_reg) begin
        rsp_rdata <= sa_out;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a default-size instance and a 12-row instance
// for out-of-range addressing, with a per-cycle invariant monitor on both.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: defaults (16 rows)
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [3:0]  a_req_addr;
  logic [7:0]  a_req_wdata, a_rsp_rdata, a_data_in, a_sa_out;
  logic        a_rsp_valid, a_rsp_err, a_pre_en, a_wr_en, a_sae;
  logic [15:0] a_wl;

  // Instance B: 12 rows
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [3:0]  b_req_addr;
  logic [7:0]  b_req_wdata, b_rsp_rdata, b_data_in, b_sa_out;
  logic        b_rsp_valid, b_rsp_err, b_pre_en, b_wr_en, b_sae;
  logic [11:0] b_wl;

  sram_ctrl dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .pre_en(a_pre_en), .wl(a_wl), .wr_en(a_wr_en), .data_in(a_data_in),
    .sae(a_sae), .sa_out(a_sa_out)
  );

  sram_ctrl #(.ROWS(12)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .pre_en(b_pre_en), .wl(b_wl), .wr_en(b_wr_en), .data_in(b_data_in),
    .sae(b_sae), .sa_out(b_sa_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input string tag, input logic pre, input logic [15:0] wlv,
                       input logic wr, input logic sa, input logic rv,
                       input logic err, input logic rdy);
    chk({tag, ".pre_en"},    32'(a_pre_en),    32'(pre));
    chk({tag, ".wl"},        32'(a_wl),        32'(wlv));
    chk({tag, ".wr_en"},     32'(a_wr_en),     32'(wr));
    chk({tag, ".sae"},       32'(a_sae),       32'(sa));
    chk({tag, ".rsp_valid"}, 32'(a_rsp_valid), 32'(rv));
    chk({tag, ".rsp_err"},   32'(a_rsp_err),   32'(err));
    chk({tag, ".req_ready"}, 32'(a_req_ready), 32'(rdy));
  endtask

  task automatic exp_b(input string tag, input logic pre, input logic [11:0] wlv,
                       input logic wr, input logic sa, input logic rv,
                       input logic err, input logic rdy);
    chk({tag, ".pre_en"},    32'(b_pre_en),    32'(pre));
    chk({tag, ".wl"},        32'(b_wl),        32'(wlv));
    chk({tag, ".wr_en"},     32'(b_wr_en),     32'(wr));
    chk({tag, ".sae"},       32'(b_sae),       32'(sa));
    chk({tag, ".rsp_valid"}, 32'(b_rsp_valid), 32'(rv));
    chk({tag, ".rsp_err"},   32'(b_rsp_err),   32'(err));
    chk({tag, ".req_ready"}, 32'(b_req_ready), 32'(rdy));
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("a_inv_pre_wl",   32'(a_pre_en && (|a_wl)), 32'd0);
      chk("a_inv_wr_onehot", 32'(a_wr_en && !$onehot(a_wl)), 32'd0);
      chk("a_inv_sae_wr",   32'(a_sae && a_wr_en), 32'd0);
      chk("b_inv_pre_wl",   32'(b_pre_en && (|b_wl)), 32'd0);
      chk("b_inv_wr_onehot", 32'(b_wr_en && !$onehot(b_wl)), 32'd0);
      chk("b_inv_sae_wr",   32'(b_sae && b_wr_en), 32'd0);
    end
  end

  initial begin
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 4'd3; a_req_wdata = 8'h55; a_sa_out = 8'h00;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 4'd1; b_req_wdata = 8'h55; b_sa_out = 8'h00;

    // Reset held two cycles with valid asserted: nothing may start.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst.pre_en",    32'(a_pre_en),    32'd0);
      chk("rst.wl",        32'(a_wl),        32'd0);
      chk("rst.wr_en",     32'(a_wr_en),     32'd0);
      chk("rst.sae",       32'(a_sae),       32'd0);
      chk("rst.rsp_valid", 32'(a_rsp_valid), 32'd0);
      chk("rst.rsp_err",   32'(a_rsp_err),   32'd0);
      chk("rst.rsp_rdata", 32'(a_rsp_rdata), 32'd0);
      chk("rst.data_in",   32'(a_data_in),   32'd0);
      chk("rst.b_pre_en",  32'(b_pre_en),    32'd0);
      chk("rst.b_data_in", 32'(b_data_in),   32'd0);
    end
    rst = 1'b0; a_req_valid = 1'b0; b_req_valid = 1'b0;
    tick();
    exp_a("post_rst", 0, 16'h0, 0, 0, 0, 0, 1);
    exp_b("post_rst_b", 0, 12'h0, 0, 0, 0, 0, 1);
    $display("txn reset released");

    // Write 0xA5 to row 3
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 4'd3; a_req_wdata = 8'hA5;
    tick(); a_req_valid = 1'b0;
    exp_a("wr.T0", 1, 16'h0, 0, 0, 0, 0, 0);
    chk("wr.T0.data_in", 32'(a_data_in), 32'h000000A5);
    tick(); exp_a("wr.T1", 0, 16'h0008, 1, 0, 0, 0, 0);
    tick(); exp_a("wr.T2", 0, 16'h0008, 1, 0, 0, 0, 0);
    tick(); exp_a("wr.T3", 0, 16'h0, 0, 0, 1, 0, 0);
    tick(); exp_a("wr.T4", 0, 16'h0, 0, 0, 0, 0, 1);
    $display("txn write addr=3 data=a5 rsp_err=%0d", a_rsp_err);

    // Read row 3, sense-amp data present only in the SENSE cycle
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 4'd3; a_req_wdata = 8'h00;
    tick(); a_req_valid = 1'b0;
    exp_a("rd.T0", 1, 16'h0, 0, 0, 0, 0, 0);
    tick(); exp_a("rd.T1", 0, 16'h0008, 0, 0, 0, 0, 0);
    tick(); exp_a("rd.T2", 0, 16'h0008, 0, 0, 0, 0, 0);
    tick(); exp_a("rd.T3", 0, 16'h0, 0, 1, 0, 0, 0);
    a_sa_out = 8'h5A;
    tick(); a_sa_out = 8'h00;
    exp_a("rd.T4", 0, 16'h0, 0, 0, 1, 0, 0);
    chk("rd.T4.rsp_rdata", 32'(a_rsp_rdata), 32'h0000005A);
    chk("rd.T4.data_in",   32'(a_data_in),   32'h000000A5);
    tick(); exp_a("rd.T5", 0, 16'h0, 0, 0, 0, 0, 1);
    chk("rd.T5.rsp_rdata", 32'(a_rsp_rdata), 32'h0000005A);
    $display("txn read addr=3 rdata=%h", a_rsp_rdata);

    // 12-row instance: out-of-range write to row 13
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 4'd13; b_req_wdata = 8'hFF;
    tick(); b_req_valid = 1'b0;
    exp_b("oob_wr.T0", 1, 12'h0, 0, 0, 0, 0, 0);
    tick(); exp_b("oob_wr.T1", 0, 12'h0, 0, 0, 0, 0, 0);
    tick(); exp_b("oob_wr.T2", 0, 12'h0, 0, 0, 0, 0, 0);
    tick(); exp_b("oob_wr.T3", 0, 12'h0, 0, 0, 1, 1, 0);
    tick(); exp_b("oob_wr.T4", 0, 12'h0, 0, 0, 0, 0, 1);
    $display("txn b write addr=13 data=ff rsp_err=1 expected");

    // In-range read on row 5 to give rsp_rdata a known value
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 4'd5;
    tick(); b_req_valid = 1'b0;
    tick(); exp_b("b_rd.T1", 0, 12'h020, 0, 0, 0, 0, 0);
    tick(); tick(); exp_b("b_rd.T3", 0, 12'h0, 0, 1, 0, 0, 0);
    b_sa_out = 8'h3C;
    tick(); b_sa_out = 8'h00;
    exp_b("b_rd.T4", 0, 12'h0, 0, 0, 1, 0, 0);
    chk("b_rd.T4.rsp_rdata", 32'(b_rsp_rdata), 32'h0000003C);
    tick();
    $display("txn b read addr=5 rdata=%h", b_rsp_rdata);

    // Out-of-range read of row 14: sae still pulses, rsp_rdata untouched
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 4'd14;
    tick(); b_req_valid = 1'b0;
    exp_b("oob_rd.T0", 1, 12'h0, 0, 0, 0, 0, 0);
    tick(); exp_b("oob_rd.T1", 0, 12'h0, 0, 0, 0, 0, 0);
    tick(); exp_b("oob_rd.T2", 0, 12'h0, 0, 0, 0, 0, 0);
    tick(); exp_b("oob_rd.T3", 0, 12'h0, 0, 1, 0, 0, 0);
    b_sa_out = 8'h77;
    tick(); b_sa_out = 8'h00;
    exp_b("oob_rd.T4", 0, 12'h0, 0, 0, 1, 1, 0);
    chk("oob_rd.T4.rsp_rdata", 32'(b_rsp_rdata), 32'h0000003C);
    chk("oob_rd.T4.data_in",   32'(b_data_in),   32'h000000FF);
    tick();
    $display("txn b read addr=14 rdata=%h (held)", b_rsp_rdata);

    // Reset asserted in T1 of a write: the request is aborted silently
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 4'd2; a_req_wdata = 8'h11;
    tick(); a_req_valid = 1'b0;
    chk("abort.T0.data_in", 32'(a_data_in), 32'h00000011);
    tick(); exp_a("abort.T1", 0, 16'h0004, 1, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk("abort.T2.pre_en",    32'(a_pre_en),    32'd0);
    chk("abort.T2.wl",        32'(a_wl),        32'd0);
    chk("abort.T2.wr_en",     32'(a_wr_en),     32'd0);
    chk("abort.T2.sae",       32'(a_sae),       32'd0);
    chk("abort.T2.rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("abort.T2.rsp_err",   32'(a_rsp_err),   32'd0);
    chk("abort.T2.rsp_rdata", 32'(a_rsp_rdata), 32'd0);
    chk("abort.T2.data_in",   32'(a_data_in),   32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort.no_rsp", 32'(a_rsp_valid), 32'd0);
    end
    chk("abort.ready", 32'(a_req_ready), 32'd1);
    $display("txn write addr=2 aborted by reset");

    // Back-to-back: valid held high across a write then a read
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 4'd7; a_req_wdata = 8'h3C;
    tick();
    a_req_we = 1'b0; a_req_addr = 4'd9; a_req_wdata = 8'h00;
    exp_a("b2b.T0", 1, 16'h0, 0, 0, 0, 0, 0);
    tick(); exp_a("b2b.T1", 0, 16'h0080, 1, 0, 0, 0, 0);
    tick(); exp_a("b2b.T2", 0, 16'h0080, 1, 0, 0, 0, 0);
    tick(); exp_a("b2b.T3", 0, 16'h0, 0, 0, 1, 0, 0);
    tick(); exp_a("b2b.T4", 0, 16'h0, 0, 0, 0, 0, 1);
    tick(); a_req_valid = 1'b0;
    exp_a("b2b.T5", 1, 16'h0, 0, 0, 0, 0, 0);
    tick(); exp_a("b2b.T6", 0, 16'h0200, 0, 0, 0, 0, 0);
    tick(); exp_a("b2b.T7", 0, 16'h0200, 0, 0, 0, 0, 0);
    tick(); exp_a("b2b.T8", 0, 16'h0, 0, 1, 0, 0, 0);
    a_sa_out = 8'hC3;
    tick(); a_sa_out = 8'h00;
    exp_a("b2b.T9", 0, 16'h0, 0, 0, 1, 0, 0);
    chk("b2b.T9.rsp_rdata", 32'(a_rsp_rdata), 32'h000000C3);
    chk("b2b.T9.data_in",   32'(a_data_in),   32'h0000003C);
    tick(); exp_a("b2b.T10", 0, 16'h0, 0, 0, 0, 0, 1);
    $display("txn write addr=7 data=3c then read addr=9 rdata=%h", a_rsp_rdata);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
